// File: rtl/timed_event_pkg.sv
// Shared types for the timed event queue: entry layout, counter states, saturation limit.
// Pure declarations; no latency or backpressure of its own.
package timed_event_pkg;

  typedef logic [63:0] ts_t;
  typedef logic [63:0] gpo_word_t;

  // ts occupies the upper half so a raw 128-bit push word maps straight onto the struct.
  typedef struct packed {
    ts_t       ts;
    gpo_word_t word;
  } event_entry_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } cnt_state_t;

  localparam logic [15:0] LATE_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/event_fifo.sv
// Single-clock FIFO with a registered head: a push into an empty queue is visible at head next cycle.
// Pushes while full are ignored; flush drops all entries and overrides a same-cycle push/pop.
module event_fifo
  import timed_event_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                push,
  input  event_entry_t        wr_data,
  input  logic                pop,
  input  logic                flush,
  output event_entry_t        head,
  output logic                head_valid,
  output logic                full,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  event_entry_t mem [DEPTH];

  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] wr_ptr_n, rd_ptr_n;
  logic                do_push, do_pop;

  assign full     = count[DEPTH_LOG2];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && head_valid && !flush;
  assign wr_ptr_n = wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
  assign rd_ptr_n = flush ? wr_ptr : rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};

  always_ff @(posedge CLK100MHZ) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= wr_ptr_n - rd_ptr_n;
      head_valid <= (wr_ptr_n != rd_ptr_n);
      // Bypass when the new head is the entry being written this cycle.
      if (do_push && (wr_ptr == rd_ptr_n)) head <= wr_data;
      else                                 head <= mem[rd_ptr_n[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: rtl/timed_event_queue.sv
// Runs the experiment timestamp counter and releases queued GPO words one cycle after their timestamp.
// wr_ready = !full; full pushes are silently refused; late entries are dropped and counted.
module timed_event_queue
  import timed_event_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [127:0]        wr_data,
  output logic                wr_ready,
  input  logic                run,
  input  logic                counter_clear,
  input  logic                flush,
  output logic [63:0]         timestamp,
  output logic                event_valid,
  output logic [127:0]        event_data,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fill_level,
  output logic                late_error,
  output logic [15:0]         late_count
);

  cnt_state_t   state, state_n;
  event_entry_t head;
  logic         head_valid, full;
  logic         cmp_en, is_match, is_late, pop;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= STOPPED;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      STOPPED: if (run)  state_n = RUNNING;
      RUNNING: if (!run) state_n = STOPPED;
      default: state_n = STOPPED;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset)                 timestamp <= '0;
    else if (counter_clear)    timestamp <= '0;
    else if (state == RUNNING) timestamp <= timestamp + 64'd1;
  end

  assign cmp_en   = head_valid && (state == RUNNING) && !flush;
  assign is_match = (head.ts == timestamp);
  assign is_late  = (head.ts < timestamp);
  assign pop      = cmp_en && (is_match || is_late);

  event_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .push       (wr_valid),
    .wr_data    (wr_data),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .count      (fill_level)
  );

  assign wr_ready = !full;
  assign busy     = head_valid;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_data  <= '0;
      late_error  <= 1'b0;
      late_count  <= '0;
    end else begin
      event_valid <= pop && is_match;
      if (pop && is_match) event_data <= head;
      if (flush) begin
        late_error <= 1'b0;
        late_count <= '0;
      end else if (pop && !is_match) begin
        late_error <= 1'b1;
        if (late_count != LATE_COUNT_MAX) late_count <= late_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_timed_event_queue.sv
// Self-checking bench: table-driven burst plus hand sequences, with a release scoreboard.
module tb_timed_event_queue;

  logic         CLK100MHZ = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic [127:0] wr_data = '0;
  logic         wr_ready;
  logic         run = 1'b0;
  logic         counter_clear = 1'b0;
  logic         flush = 1'b0;
  logic [63:0]  timestamp;
  logic         event_valid;
  logic [127:0] event_data;
  logic         busy;
  logic [4:0]   fill_level;
  logic         late_error;
  logic [15:0]  late_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] data;
    logic [63:0]  ts;
    int           fill;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct {
    logic [63:0] ts;
    logic [63:0] word;
    logic [63:0] exp_evt_ts;
    int          exp_fill;
  } vec_t;
  vec_t vecs [4];

  timed_event_queue #(.DEPTH_LOG2(4)) dut (
    .CLK100MHZ     (CLK100MHZ),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .run           (run),
    .counter_clear (counter_clear),
    .flush         (flush),
    .timestamp     (timestamp),
    .event_valid   (event_valid),
    .event_data    (event_data),
    .busy          (busy),
    .fill_level    (fill_level),
    .late_error    (late_error),
    .late_count    (late_count)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Every release is matched against the oldest expected release.
  always @(negedge CLK100MHZ) begin
    if (event_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got release at ts=%0d expected none", timestamp);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_data", event_data, mon_e.data);
        chk("evt_ts", 128'(timestamp), 128'(mon_e.ts));
        chk("evt_fill", 128'(fill_level), 128'(mon_e.fill));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; wr_valid = 1'b0; flush = 1'b0; counter_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [63:0] ts, input logic [63:0] word);
    wr_valid = 1'b1;
    wr_data  = {ts, word};
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic expect_rel(input logic [63:0] ts, input logic [63:0] word, input int fill);
    sb_t e;
    e.data = {ts, word};
    e.ts   = ts + 64'd1;
    e.fill = fill;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  task automatic run_until(input logic [63:0] target, input int budget);
    int n = 0;
    while (timestamp !== target && n < budget) begin
      tick();
      n++;
    end
    chk("reach_ts", 128'(timestamp), 128'(target));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ts: 64'd10, word: 64'hB0, exp_evt_ts: 64'd11, exp_fill: 3};
    vecs[1] = '{ts: 64'd11, word: 64'hB1, exp_evt_ts: 64'd12, exp_fill: 2};
    vecs[2] = '{ts: 64'd12, word: 64'hB2, exp_evt_ts: 64'd13, exp_fill: 1};
    vecs[3] = '{ts: 64'd20, word: 64'hB3, exp_evt_ts: 64'd21, exp_fill: 0};

    // Reset values
    do_reset();
    chk("rst_ts", 128'(timestamp), 128'(0));
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("rst_event_valid", 128'(event_valid), 128'(0));
    chk("rst_event_data", event_data, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_fill", 128'(fill_level), 128'(0));
    chk("rst_late_error", 128'(late_error), 128'(0));
    chk("rst_late_count", 128'(late_count), 128'(0));

    // Single event
    do_reset();
    run = 1'b1;
    expect_rel(64'd100, 64'hA5, 0);
    push(64'd100, 64'hA5);
    drain(200);
    chk("single_busy_after", 128'(busy), 128'(0));
    tick();
    tick();

    // Burst from the vector table
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb_t e;
      e.data = {vecs[i].ts, vecs[i].word};
      e.ts   = vecs[i].exp_evt_ts;
      e.fill = vecs[i].exp_fill;
      sb.push_back(e);
      push(vecs[i].ts, vecs[i].word);
    end
    chk("burst_fill_4", 128'(fill_level), 128'(4));
    run = 1'b1;
    drain(100);
    chk("burst_fill_0", 128'(fill_level), 128'(0));
    chk("burst_busy", 128'(busy), 128'(0));
    chk("burst_no_late", 128'(late_error), 128'(0));

    // Late entry, then a normal one, then flush clears errors but keeps event_data
    do_reset();
    run = 1'b1;
    run_until(64'd50, 100);
    push(64'd30, 64'h30);
    expect_rel(64'd60, 64'h60, 0);
    push(64'd60, 64'h60);
    drain(100);
    chk("late_error", 128'(late_error), 128'(1));
    chk("late_count", 128'(late_count), 128'(1));
    pulse_flush();
    chk("flush_late_error", 128'(late_error), 128'(0));
    chk("flush_late_count", 128'(late_count), 128'(0));
    chk("flush_keeps_data", event_data, {64'd60, 64'h60});

    // Duplicate timestamps: second one is late
    do_reset();
    expect_rel(64'd5, 64'hD1, 1);
    push(64'd5, 64'hD1);
    push(64'd5, 64'hD2);
    run = 1'b1;
    drain(50);
    tick();
    tick();
    chk("dup_late_count", 128'(late_count), 128'(1));
    chk("dup_busy", 128'(busy), 128'(0));

    // Full queue, refused push, flush
    do_reset();
    for (int i = 0; i < 16; i++) push(64'd1000 + 64'(i), 64'(i));
    chk("full_wr_ready", 128'(wr_ready), 128'(0));
    push(64'd2000, 64'hFF);
    chk("full_fill", 128'(fill_level), 128'(16));
    pulse_flush();
    chk("flushed_fill", 128'(fill_level), 128'(0));
    chk("flushed_busy", 128'(busy), 128'(0));
    chk("flushed_wr_ready", 128'(wr_ready), 128'(1));
    chk("flushed_late_error", 128'(late_error), 128'(0));

    // Counter pause, resume, clear
    do_reset();
    run = 1'b1;
    expect_rel(64'd45, 64'h45, 0);
    push(64'd45, 64'h45);
    run_until(64'd39, 100);
    run = 1'b0;
    tick();
    repeat (20) tick();
    chk("paused_ts", 128'(timestamp), 128'(40));
    chk("paused_pending", 128'(sb.size()), 128'(1));
    run = 1'b1;
    drain(50);
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
    chk("clear_ts", 128'(timestamp), 128'(0));
    tick();
    chk("clear_keeps_running", 128'(timestamp), 128'(1));

    // Reset with a match due next cycle
    do_reset();
    for (int i = 0; i < 5; i++) push(64'd20 + 64'(i), 64'hC0 + 64'(i));
    run = 1'b1;
    run_until(64'd19, 100);
    reset = 1'b1;
    run = 1'b0;
    tick();
    chk("mid_rst_ts", 128'(timestamp), 128'(0));
    chk("mid_rst_event_valid", 128'(event_valid), 128'(0));
    chk("mid_rst_fill", 128'(fill_level), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("mid_rst_event_data", event_data, 128'(0));
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_rst_quiet", 128'(event_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_event_queue.md
# timed_event_queue

Timestamped event buffer that sits directly upstream of the RFDC DAC controller and its GPO core. Software pushes 128-bit entries of {timestamp, 64-bit GPO word}. The block runs the 64-bit experiment timestamp counter and releases each queued word as a one-cycle `event_valid` strobe when the counter reaches that entry's timestamp. Its outputs drive the controller's `counter_matched` and `gpo_in` inputs; `busy` is fed back to the controller.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `CLK100MHZ` in, 1 bit: clock.
- `reset` in, 1 bit: synchronous, active-high.
- `wr_valid` in, 1 bit: entry-push request.
- `wr_data` in, 128 bits: entry; [127:64] is the timestamp, [63:0] is the GPO word.
- `wr_ready` out, 1 bit: combinational, equals !full.
- `run` in, 1 bit: level; the counter advances while high.
- `counter_clear` in, 1 bit: pulse; sets the counter to 0.
- `flush` in, 1 bit: pulse; empties the queue and clears error state.
- `timestamp` out, 64 bits: current counter value.
- `event_valid` out, 1 bit: one-cycle release strobe; connects to `counter_matched`.
- `event_data` out, 128 bits: the released entry, held until the next release; connects to `gpo_in`.
- `busy` out, 1 bit: registered; high while the queue is non-empty.
- `fill_level` out, DEPTH_LOG2+1 bits: current entry count.
- `late_error` out, 1 bit: sticky; an entry was dropped because it was late.
- `late_count` out, 16 bits: number of dropped entries; saturates at 16'hFFFF.

## Operation
- **Counter states.** STOPPED and RUNNING.
  - STOPPED goes to RUNNING when `run`=1; RUNNING goes to STOPPED when `run`=0.
  - In RUNNING, `timestamp` increments by 1 each cycle and wraps from 2^64-1 to 0.
  - `counter_clear` takes priority over increment: `timestamp` is 0 on the next cycle, and the current state is kept.
- **Push.**
  - `wr_valid && wr_ready` writes the entry at the tail.
  - A push while full is not accepted; the entry is not stored and no error is raised.
  - Timestamps must be non-decreasing; the block does not check this.
- **Head compare.** Performed each cycle while non-empty and RUNNING, using the registered head entry.
  - `head_ts == timestamp`: pop the head, load `event_data`, assert `event_valid` on the next cycle.
  - `head_ts < timestamp` (unsigned): pop the head, set `late_error`, increment `late_count`, no `event_valid`.
  - `head_ts > timestamp`: hold.
  - At most one pop per cycle.
- **STOPPED.** No compare and no pop; entries wait.
- **Simultaneous push and pop.** Both take effect; `fill_level` is unchanged.
- **Flush.**
  - Read pointer is set to the write pointer.
  - `fill_level`, `late_error` and `late_count` go to 0.
  - `event_data` is kept.
  - Flush wins over a push in the same cycle; that entry is dropped.
- **Reset values.**
  - Counter STOPPED, `timestamp` 0, queue empty, `wr_ready` 1.
  - `event_valid` 0, `event_data` 0, `busy` 0, `fill_level` 0, `late_error` 0, `late_count` 0.
  - Reset mid-operation discards all entries; no `event_valid` pulse follows.

## Timing
- **Write to head.** An entry pushed into an empty queue at edge N is compare-eligible in cycle N+1.
- **Release latency.** `event_valid` is high in the cycle after the one in which `timestamp == head_ts`, i.e. while `timestamp == head_ts+1`. This latency is fixed at 1 cycle.
- **Back-to-back release.** Entries with consecutive timestamps T and T+1 release on consecutive cycles.
- **Duplicate timestamps.** The second of two equal timestamps is late by one cycle and is dropped with `late_error`.
- **Registered outputs.** `busy` and `fill_level` reflect the state after the current edge.
- **Wrap.** Comparison is plain unsigned; entries queued across a counter wrap count as late.

## Structure
- **Package `timed_event_pkg`:**
  - `ts_t` (64-bit);
  - `gpo_word_t` (64-bit);
  - packed struct `event_entry_t` {ts, word};
  - constant `LATE_COUNT_MAX`.
- **Sub-module `event_fifo`:**
  - synchronous single-clock FIFO, parameterised by DEPTH_LOG2;
  - registered head output with a valid flag;
  - pointers one bit wider than the address, for full/empty detection;
  - a flush port.
- **Top module:** counter FSM, comparator, pop control, output registers and error counters.

## Test plan
- **Single event.** Push {ts=100, word=64'hA5}, set `run` from cycle 0. Expect exactly one `event_valid`, while `timestamp`=101; `event_data[63:0]`=64'hA5; `busy` 0 afterwards.
- **Burst.** Push ts 10, 11, 12 and 20. Expect `event_valid` at `timestamp` 11, 12, 13 and 21; `fill_level` steps 4→3→2→1→0.
- **Late entry.** Run to `timestamp` 50, then push ts=30. Expect no `event_valid`, `late_error`=1, `late_count`=1; a following ts=60 still releases at 61.
- **Full queue.**
  - Push 17 entries with `run`=0: `wr_ready` is 0 after the 16th, the 17th is not stored, `fill_level`=16.
  - Then assert `flush`: `fill_level`=0, `late_error`=0.
- **Counter control.**
  - Pause `run` at `timestamp` 40 with ts=45 queued, hold 20 cycles: no release and `timestamp` stays 40.
  - Resume: release at 46.
  - `counter_clear` at 46 gives `timestamp`=0 on the next cycle.
- **Reset mid-operation.** Assert `reset` with 5 entries queued and a match due next cycle. Expect no `event_valid`, and all outputs at their reset values on the next cycle.
